// File: rtl/kamus_dmem_arbiter.sv
// Round-robin arbiter sharing the single-port L1 data memory between the LSU (port 0) and the debug/DMA port (port 1).
// Optional ACCESS-state watchdog enabled by defining KAMUS_DMEM_ARB_TIMEOUT_EN.
module kamus_dmem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_be_i,
    output logic                lsu_gnt_o,
    output logic                lsu_rvalid_o,
    output logic                lsu_stall_o,

    input  logic                dbg_req_i,
    input  logic                dbg_we_i,
    input  logic [ADDR_W-1:0]   dbg_addr_i,
    input  logic [DATA_W-1:0]   dbg_wdata_i,
    input  logic [DATA_W/8-1:0] dbg_be_i,
    output logic                dbg_gnt_o,
    output logic                dbg_rvalid_o,

    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t              state;
    state_t              state_next;

    // last_gnt = 1 means the debug port won the most recent grant
    logic                last_gnt;
    logic                sel_id;
    logic                lsu_win;
    logic                dbg_win;
    logic                any_win;
    logic                mem_done;
    logic                timeout_hit;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;

    always_comb begin
        lsu_win = 1'b0;
        dbg_win = 1'b0;
        if (state == IDLE) begin
            if (lsu_req_i && dbg_req_i) begin
                lsu_win = last_gnt;
                dbg_win = ~last_gnt;
            end else begin
                lsu_win = lsu_req_i;
                dbg_win = dbg_req_i;
            end
        end
    end

    assign any_win  = lsu_win | dbg_win;
    assign mem_done = (state == ACCESS) && mem_ack_i;

`ifdef KAMUS_DMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] acc_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_cnt <= '0;
        end else if (state == ACCESS) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end else begin
            acc_cnt <= '0;
        end
    end

    // An ack arriving in the expiry cycle takes priority over the abort
    assign timeout_hit = (state == ACCESS) && !mem_ack_i &&
                         (acc_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (mem_done) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
    assign err_q              = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_win) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_done || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt    <= 1'b1;
            sel_id      <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
            rdata_q     <= '0;
        end else begin
            if (any_win) begin
                last_gnt    <= dbg_win;
                sel_id      <= dbg_win;
                mem_we_o    <= dbg_win ? dbg_we_i    : lsu_we_i;
                mem_addr_o  <= dbg_win ? dbg_addr_i  : lsu_addr_i;
                mem_wdata_o <= dbg_win ? dbg_wdata_i : lsu_wdata_i;
                mem_be_o    <= dbg_win ? dbg_be_i    : lsu_be_i;
            end
            // Stores and aborted accesses report zero read data
            if (mem_done) begin
                rdata_q <= mem_we_o ? '0 : mem_rdata_i;
            end else if (timeout_hit) begin
                rdata_q <= '0;
            end
        end
    end

    always_comb begin
        lsu_gnt_o    = lsu_win;
        dbg_gnt_o    = dbg_win;
        mem_req_o    = (state == ACCESS);
        lsu_rvalid_o = (state == RESP) && !sel_id;
        dbg_rvalid_o = (state == RESP) && sel_id;
        err_o        = (state == RESP) && err_q;
        lsu_stall_o  = lsu_req_i && !((state == RESP) && !sel_id);
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_kamus_dmem_arbiter.sv
// Directed self-checking bench for kamus_dmem_arbiter: handshake timing, round-robin order, reset abort, stray acks.
module tb_kamus_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk_i;
    logic              rst_i;
    logic              lsu_req_i, lsu_we_i;
    logic [ADDR_W-1:0] lsu_addr_i;
    logic [DATA_W-1:0] lsu_wdata_i;
    logic [BE_W-1:0]   lsu_be_i;
    logic              lsu_gnt_o, lsu_rvalid_o, lsu_stall_o;
    logic              dbg_req_i, dbg_we_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_wdata_i;
    logic [BE_W-1:0]   dbg_be_i;
    logic              dbg_gnt_o, dbg_rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              err_o;
    logic              mem_req_o, mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    int checks   = 0;
    int failures = 0;

    kamus_dmem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .lsu_req_i(lsu_req_i),
        .lsu_we_i(lsu_we_i),
        .lsu_addr_i(lsu_addr_i),
        .lsu_wdata_i(lsu_wdata_i),
        .lsu_be_i(lsu_be_i),
        .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o),
        .lsu_stall_o(lsu_stall_o),
        .dbg_req_i(dbg_req_i),
        .dbg_we_i(dbg_we_i),
        .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i),
        .dbg_be_i(dbg_be_i),
        .dbg_gnt_o(dbg_gnt_o),
        .dbg_rvalid_o(dbg_rvalid_o),
        .rdata_o(rdata_o),
        .err_o(err_o),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // port 0 = LSU, port 1 = debug
    task automatic applyStimulus(input bit port, input logic req, input logic we,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                                 input logic [BE_W-1:0] be);
        if (port == 1'b0) begin
            lsu_req_i = req; lsu_we_i = we; lsu_addr_i = addr; lsu_wdata_i = wdata; lsu_be_i = be;
        end else begin
            dbg_req_i = req; dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wdata; dbg_be_i = be;
        end
    endtask

    task automatic applyMem(input logic ack, input logic [DATA_W-1:0] rdata);
        mem_ack_i   = ack;
        mem_rdata_i = rdata;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
        applyMem(1'b0, '0);
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        resetDut();
        rst_i = 1'b1;
        #1;
        checkOutput("rst_mem_req", mem_req_o, 1'b0);
        checkOutput("rst_rdata", rdata_o, 32'h0);
        checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
        checkOutput("rst_rvalid", {lsu_rvalid_o, dbg_rvalid_o, err_o}, 3'b000);
        @(negedge clk_i);
        rst_i = 1'b0;

        // LSU load, ack in the first ACCESS cycle
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        #1;
        checkOutput("t1_c0_gnt", {lsu_gnt_o, dbg_gnt_o}, 2'b10);
        checkOutput("t1_c0_stall", lsu_stall_o, 1'b1);
        checkOutput("t1_c0_memreq", mem_req_o, 1'b0);
        tick();
        applyMem(1'b1, 32'hDEADBEEF);
        #1;
        checkOutput("t1_c1_memreq", mem_req_o, 1'b1);
        checkOutput("t1_c1_addr", mem_addr_o, 32'h100);
        checkOutput("t1_c1_we", mem_we_o, 1'b0);
        checkOutput("t1_c1_stall", lsu_stall_o, 1'b1);
        checkOutput("t1_c1_gnt", lsu_gnt_o, 1'b0);
        tick();
        applyMem(1'b0, 32'h0);
        #1;
        checkOutput("t1_c2_rvalid", {lsu_rvalid_o, dbg_rvalid_o}, 2'b10);
        checkOutput("t1_c2_rdata", rdata_o, 32'hDEADBEEF);
        checkOutput("t1_c2_err", err_o, 1'b0);
        checkOutput("t1_c2_stall", lsu_stall_o, 1'b0);
        checkOutput("t1_c2_memreq", mem_req_o, 1'b0);
        checkOutput("t1_c2_no_gnt", lsu_gnt_o, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("t1_c3_rvalid", lsu_rvalid_o, 1'b0);
        checkOutput("t1_c3_rdata_hold", rdata_o, 32'hDEADBEEF);

        // Both ports requesting from reset: LSU, debug, LSU
        resetDut();
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
        applyMem(1'b1, 32'h11112222);
        #1;
        checkOutput("t2_g0", {lsu_gnt_o, dbg_gnt_o}, 2'b10);
        tick(); #1;
        checkOutput("t2_a0_addr", mem_addr_o, 32'h200);
        tick(); #1;
        checkOutput("t2_r0", {lsu_rvalid_o, dbg_rvalid_o}, 2'b10);
        checkOutput("t2_r0_gnt", {lsu_gnt_o, dbg_gnt_o}, 2'b00);
        tick(); #1;
        checkOutput("t2_g1", {lsu_gnt_o, dbg_gnt_o}, 2'b01);
        checkOutput("t2_g1_stall", lsu_stall_o, 1'b1);
        tick(); #1;
        checkOutput("t2_a1_addr", mem_addr_o, 32'h300);
        tick(); #1;
        checkOutput("t2_r1", {lsu_rvalid_o, dbg_rvalid_o}, 2'b01);
        checkOutput("t2_r1_rdata", rdata_o, 32'h11112222);
        tick(); #1;
        checkOutput("t2_g2", {lsu_gnt_o, dbg_gnt_o}, 2'b10);

        // Debug store with ack delayed to the fifth ACCESS cycle
        resetDut();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 32'h55AA1234, 4'b0011);
        #1;
        checkOutput("t3_gnt", {lsu_gnt_o, dbg_gnt_o}, 2'b01);
        for (int k = 1; k <= 5; k++) begin
            tick();
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            #1;
            checkOutput($sformatf("t3_a%0d_fields", k),
                        {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
                        {1'b1, 1'b1, 4'b0011, 32'h40, 32'h55AA1234});
            checkOutput($sformatf("t3_a%0d_quiet", k),
                        {lsu_stall_o, lsu_rvalid_o, dbg_rvalid_o}, 3'b000);
            if (k == 5) applyMem(1'b1, 32'hFFFFFFFF);
        end
        tick();
        applyMem(1'b0, 32'h0);
        #1;
        checkOutput("t3_resp", {lsu_rvalid_o, dbg_rvalid_o, mem_req_o}, 3'b010);
        checkOutput("t3_rdata", rdata_o, 32'h0);
        tick(); #1;
        checkOutput("t3_after", {dbg_rvalid_o, mem_req_o, lsu_stall_o}, 3'b000);

        // Reset during the second ACCESS cycle aborts the access
        resetDut();
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
        #1;
        checkOutput("t4_gnt", lsu_gnt_o, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("t4_a1_memreq", mem_req_o, 1'b1);
        tick(); #1;
        rst_i = 1'b1;
        #1;
        checkOutput("t4_rst_memreq", mem_req_o, 1'b0);
        checkOutput("t4_rst_addr", mem_addr_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick(); #1;
        checkOutput("t4_no_rvalid", {lsu_rvalid_o, dbg_rvalid_o, mem_req_o}, 3'b000);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h84, 32'h0, 4'hF);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h88, 32'h0, 4'hF);
        #1;
        checkOutput("t4_regnt", {lsu_gnt_o, dbg_gnt_o}, 2'b10);
        tick(); #1;
        checkOutput("t4_regnt_addr", mem_addr_o, 32'h84);

        // Stray acks while idle have no effect
        resetDut();
        applyMem(1'b1, 32'hA5A5A5A5);
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            checkOutput($sformatf("t5_stray%0d", k),
                        {mem_req_o, lsu_rvalid_o, dbg_rvalid_o, lsu_gnt_o, dbg_gnt_o}, 5'b00000);
        end
        checkOutput("t5_rdata", rdata_o, 32'h0);
        applyMem(1'b0, 32'h0);

`ifdef KAMUS_DMEM_ARB_TIMEOUT_EN
        // Watchdog expiry after four ACCESS cycles, then ack on the fourth cycle
        resetDut();
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        #1;
        checkOutput("t6_gnt", lsu_gnt_o, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            #1;
            checkOutput($sformatf("t6_a%0d", k), {mem_req_o, lsu_rvalid_o}, 2'b10);
        end
        tick(); #1;
        checkOutput("t6_to_resp", {lsu_rvalid_o, err_o, mem_req_o}, 3'b110);
        checkOutput("t6_to_rdata", rdata_o, 32'h0);
        tick(); #1;
        checkOutput("t6_err_clear", err_o, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
        for (int k = 1; k <= 4; k++) begin
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            if (k == 4) applyMem(1'b1, 32'hCAFE0001);
        end
        tick();
        applyMem(1'b0, 32'h0);
        #1;
        checkOutput("t6_ack_resp", {lsu_rvalid_o, err_o}, 2'b10);
        checkOutput("t6_ack_rdata", rdata_o, 32'hCAFE0001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
